// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and constants for the modulo counter with divisibility flag
//
// Purpose: state encoding of the residue recompute FSM, count direction constants,
//          and the residue width helper (RES_W = $clog2(DIV)).
// Ports:   none (package).
package cnt_pkg;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_CALC = 1'b1
  } cnt_state_t;

  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;

  // Residue register width; DIV=2 still needs one bit.
  function automatic int cnt_res_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/cnt_residue_calc.sv
// rtl/cnt_residue_calc.sv - bit-serial restoring remainder of a WIDTH-bit value by DIV
//
// Purpose: computes value % DIV one bit per cycle, MSB first, in WIDTH cycles.
//          A start while busy restarts the pass with the new value.
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   start_i    in   begin a pass on value_i (sampled on the same edge)
//   value_i    in   WIDTH-bit value to reduce
//   busy_o     out  pass in progress (exactly WIDTH cycles)
//   done_o     out  high during the last pass cycle; residue_o is final then
//   residue_o  out  partial remainder after the current bit
module cnt_residue_calc
  import cnt_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DIV   = 3,
  localparam int RES_W = cnt_res_w(DIV)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RES_W-1:0] residue_o
);

  localparam int             IDX_W = $clog2(WIDTH);
  localparam logic [RES_W:0] DIV_T = (RES_W + 1)'(DIV);

  cnt_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [RES_W-1:0] rem_q;
  logic [WIDTH-1:0] val_q;
  logic [RES_W:0]   trial;
  logic [RES_W-1:0] rem_next;

  // Shift in the next bit; subtract DIV once if the trial remainder reaches it.
  always_comb begin
    trial    = {rem_q, val_q[idx_q]};
    rem_next = (trial >= DIV_T) ? RES_W'(trial - DIV_T) : trial[RES_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CNT_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      val_q   <= '0;
    end else if (start_i) begin
      state_q <= CNT_CALC;
      idx_q   <= IDX_W'(WIDTH - 1);
      rem_q   <= '0;
      val_q   <= value_i;
    end else if (state_q == CNT_CALC) begin
      rem_q <= rem_next;
      if (idx_q == '0) begin
        state_q <= CNT_IDLE;
      end else begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

  assign busy_o    = (state_q == CNT_CALC);
  assign done_o    = (state_q == CNT_CALC) && (idx_q == '0) && !start_i;
  assign residue_o = rem_next;

endmodule

// File: rtl/mod_counter_divchk.sv
// rtl/mod_counter_divchk.sv - up/down modulo counter with load and registered count%DIV==0 flag
//
// Purpose: counts 0..L (L = limit_sel ? limit : RST_LIMIT), wraps both ways, tracks
//          count%DIV incrementally and recomputes it serially after load or down-wrap.
// Config:  CNT_WRAP_IRQ_EN enables the sticky wrap interrupt (irq/irq_clr).
// Ports:
//   clk, rstn           clock (rising), asynchronous active-low reset
//   en, dir             step enable, direction (1=up, 0=down)
//   load, load_val      parallel load, wins over en
//   limit_sel, limit    select runtime limit instead of RST_LIMIT
//   count, wrap         current count, one-cycle wrap pulse
//   div_hit, busy       count%DIV==0 (only when idle), residue recompute active
//   irq, irq_clr        sticky wrap interrupt and its clear
module mod_counter_divchk
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV       = 3,
  parameter int RST_LIMIT = 300
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             limit_sel,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             div_hit,
  output logic             busy,
  output logic             irq,
  input  logic             irq_clr
);

  localparam int               RES_W   = cnt_res_w(DIV);
  localparam logic [RES_W-1:0] RES_MAX = RES_W'(DIV - 1);
  localparam logic [WIDTH-1:0] RST_L   = WIDTH'(RST_LIMIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             wrap_q, wrap_d;
  logic             div_hit_q, div_hit_d;
  logic [WIDTH-1:0] lim;
  logic             calc_start, calc_busy, calc_done;
  logic [RES_W-1:0] calc_res;

  assign lim = limit_sel ? limit : RST_L;

  always_comb begin
    count_d    = count_q;
    res_d      = res_q;
    wrap_d     = 1'b0;
    calc_start = 1'b0;
    if (load) begin
      count_d    = load_val;
      calc_start = 1'b1;
    end else if (calc_busy) begin
      if (calc_done) begin
        res_d = calc_res;
      end
    end else if (en) begin
      if (dir == CNT_DIR_UP) begin
        // >= rather than == also catches a limit lowered below the count.
        if (count_q >= lim) begin
          count_d = '0;
          res_d   = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
          res_d   = (res_q == RES_MAX) ? '0 : res_q + RES_W'(1);
        end
      end else begin
        // Down-wrap lands on an arbitrary L, so its residue is recomputed.
        if (count_q == '0) begin
          count_d    = lim;
          wrap_d     = 1'b1;
          calc_start = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
          res_d   = (res_q == '0) ? RES_MAX : res_q - RES_W'(1);
        end
      end
    end
    // Flag follows the residue that will be valid next cycle, masked while busy.
    div_hit_d = !(calc_start || (calc_busy && !calc_done)) && (res_d == '0);
  end

  cnt_residue_calc #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) u_calc (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (calc_start),
    .value_i   (count_d),
    .busy_o    (calc_busy),
    .done_o    (calc_done),
    .residue_o (calc_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q   <= '0;
      res_q     <= '0;
      wrap_q    <= 1'b0;
      div_hit_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      res_q     <= res_d;
      wrap_q    <= wrap_d;
      div_hit_q <= div_hit_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign div_hit = div_hit_q;
  assign busy    = calc_busy;

`ifdef CNT_WRAP_IRQ_EN
  logic irq_q;

  // Set has priority so a wrap coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else if (wrap_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter_divchk.sv
// tb/tb_mod_counter_divchk.sv - self-checking bench for mod_counter_divchk (WIDTH=16, DIV=3, RST_LIMIT=300)
module tb_mod_counter_divchk;

  localparam int W = 16;
`ifdef CNT_WRAP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn, en, dir, load, limit_sel, irq_clr;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         wrap, div_hit, busy, irq;

  int errors = 0;
  int checks = 0;

  // Reference state: count value, remaining busy cycles, last wrap, irq.
  int m_count, m_busy;
  bit m_wrap, m_irq;
  int wraps_seen;

  mod_counter_divchk #(.WIDTH(W), .DIV(3), .RST_LIMIT(300)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .limit_sel (limit_sel),
    .limit     (limit),
    .count     (count),
    .wrap      (wrap),
    .div_hit   (div_hit),
    .busy      (busy),
    .irq       (irq),
    .irq_clr   (irq_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_busy  = 0;
    m_wrap  = 0;
    m_irq   = 0;
  endtask

  task automatic model_step();
    int l;
    bit w;
    w = 0;
    if (IRQ_ON) begin
      if (m_wrap) m_irq = 1;
      else if (irq_clr) m_irq = 0;
    end
    l = limit_sel ? int'(limit) : 300;
    if (load) begin
      m_count = int'(load_val);
      m_busy  = W;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (en) begin
      if (dir) begin
        if (m_count >= l) begin m_count = 0; w = 1; end
        else m_count++;
      end else begin
        if (m_count == 0) begin m_count = l; w = 1; m_busy = W; end
        else m_count--;
      end
    end
    m_wrap = w;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("count", count, m_count);
    check("wrap", wrap, m_wrap);
    check("busy", busy, m_busy > 0);
    check("div_hit", div_hit, (m_busy == 0) && (m_count % 3 == 0));
    check("irq", irq, m_irq);
    if (wrap) wraps_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v, input bit with_en);
    load = 1; load_val = W'(v); en = with_en;
    tick();
    load = 0;
  endtask

  task automatic reset_check(input string tag);
    rstn = 0;
    #1;
    model_reset();
    check({tag, "_count"}, count, 0);
    check({tag, "_wrap"}, wrap, 0);
    check({tag, "_div_hit"}, div_hit, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_irq"}, irq, 0);
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    rstn = 0; en = 0; dir = 1; load = 0; load_val = '0;
    limit_sel = 0; limit = '0; irq_clr = 0;
    model_reset();
    wraps_seen = 0;
    repeat (2) @(negedge clk);
    reset_check("reset");

    // 1: free-run up through the default limit
    en = 1; dir = 1;
    wraps_seen = 0;
    ticks(301);
    check("t1_count", count, 0);
    check("t1_wraps", wraps_seen, 1);

    // 2: load 100, recompute, two steps up
    en = 0;
    do_load(100, 1'b0);
    check("t2_busy", busy, 1);
    en = 1;
    ticks(W);
    check("t2_held", count, 100);
    check("t2_hit0", div_hit, 0);
    ticks(2);
    check("t2_count", count, 102);
    check("t2_hit1", div_hit, 1);

    // 3: down from 1 with limit 10
    en = 0;
    do_load(1, 1'b0);
    ticks(W);
    en = 1; dir = 0; limit_sel = 1; limit = 10;
    ticks(2);
    check("t3_wrapcnt", count, 10);
    check("t3_wrap", wrap, 1);
    ticks(W);
    check("t3_hit0", div_hit, 0);
    tick();
    check("t3_count9", count, 9);
    check("t3_hit1", div_hit, 1);

    // 4: load with en, then reload mid-pass
    dir = 1;
    do_load(7, 1'b1);
    check("t4_count", count, 7);
    check("t4_nowrap", wrap, 0);
    ticks(5);
    do_load(9, 1'b1);
    ticks(W - 1);
    check("t4_restart_busy", busy, 1);
    tick();
    check("t4_hit", div_hit, 1);
    check("t4_count9", count, 9);

    // 5: lower limit below count, then reset mid-CALC
    limit_sel = 0; en = 0;
    do_load(140, 1'b0);
    ticks(W);
    en = 1; dir = 1;
    ticks(10);
    check("t5_count150", count, 150);
    limit_sel = 1; limit = 120;
    tick();
    check("t5_count0", count, 0);
    check("t5_wrap", wrap, 1);
    dir = 0;
    tick();
    ticks(5);
    reset_check("midcalc");

    // 6: irq set by wrap; clear coinciding with a wrap loses to the set
    en = 0;
    do_load(0, 1'b0);
    ticks(W);
    en = 1; dir = 1; limit_sel = 1; limit = 0;
    tick();
    tick();
    irq_clr = 1;
    tick();
    check("t6_irq_set_wins", irq, IRQ_ON);
    en = 0;
    tick();
    tick();
    check("t6_irq_cleared", irq, 0);
    irq_clr = 0;

    // Randomized run against the reference model
    for (int i = 0; i < 2000; i++) begin
      load      = ($urandom_range(0, 19) == 0);
      load_val  = W'($urandom_range(0, 60));
      en        = ($urandom_range(0, 3) != 0);
      dir       = $urandom_range(0, 1);
      limit_sel = ($urandom_range(0, 7) != 0);
      limit     = W'($urandom_range(0, 40));
      irq_clr   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
